// File: rtl/master_pkg.sv
// Shared constants for the master tile sequencer: default widths and FSM state codes.
package master_pkg;
   localparam int DEF_ADDR_WIDTH   = 8;
   localparam int DEF_WIDTH_HEIGHT = 16;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;
endpackage

// File: rtl/tile_extent.sv
// Tile edge for one dimension: min(width_height, remaining) - 1, purely combinational.
// Expects remaining >= 1; the sequencer never issues a tile with nothing left.
module tile_extent #(
   parameter int addr_width   = 8,
   parameter int width_height = 16
) (
   input  logic [addr_width-1:0]           remaining,
   output logic [$clog2(width_height)-1:0] extent
);
   localparam int CW = $clog2(width_height);
   localparam logic [addr_width:0] WH_EXT = (addr_width+1)'(width_height);
   localparam logic [CW-1:0]       WH_M1  = CW'(width_height - 1);

   always_comb begin
      if ({1'b0, remaining} >= WH_EXT)
         extent = WH_M1;
      else
         extent = CW'(remaining - addr_width'(1));
   end
endmodule

// File: rtl/master_tile_sequencer.sv
// Walks a matrix in systolic-array tiles (column-tile outer), one mc_active launch per tile,
// next launch the cycle after mc_done; optional abort port under MASTER_TILE_SEQ_ABORT_EN.
module master_tile_sequencer
   import master_pkg::*;
#(
   parameter int addr_width   = DEF_ADDR_WIDTH,
   parameter int width_height = DEF_WIDTH_HEIGHT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [addr_width-1:0]           mat_base_addr,
   input  logic [addr_width-1:0]           mat_rows,
   input  logic [addr_width-1:0]           mat_cols,
   output logic                            mc_active,
   output logic [addr_width-1:0]           mc_base_addr,
   output logic [$clog2(width_height)-1:0] mc_num_row,
   output logic [$clog2(width_height)-1:0] mc_num_col,
   input  logic                            mc_done,
`ifdef MASTER_TILE_SEQ_ABORT_EN
   input  logic                            abort,
`endif
   output logic                            busy,
   output logic                            done
);
   localparam int CW = $clog2(width_height);
   localparam logic [addr_width:0]   WH_EXT = (addr_width+1)'(width_height);
   localparam logic [addr_width-1:0] WH_A   = addr_width'(width_height);

   logic [1:0]            state;
   logic [addr_width-1:0] rows_q, row_left, col_left, row_addr, col_base;
   logic [addr_width-1:0] nxt_row_left, nxt_col_left, nxt_row_addr, nxt_col_base;
   logic [CW-1:0]         ext_row, ext_col;
   logic                  more_rows, more_cols, abort_q, abort_hit;

`ifdef MASTER_TILE_SEQ_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign more_rows = {1'b0, row_left} > WH_EXT;
   assign more_cols = {1'b0, col_left} > WH_EXT;

   // Next tile position: from the inputs when starting, else step down a column, else to the next column tile.
   always_comb begin
      nxt_row_left = row_left;
      nxt_col_left = col_left;
      nxt_row_addr = row_addr;
      nxt_col_base = col_base;
      if (state == S_IDLE) begin
         nxt_row_left = mat_rows;
         nxt_col_left = mat_cols;
         nxt_row_addr = mat_base_addr;
         nxt_col_base = mat_base_addr;
      end else if (more_rows) begin
         nxt_row_left = row_left - WH_A;
         nxt_row_addr = row_addr + WH_A;
      end else begin
         nxt_row_left = rows_q;
         nxt_col_left = col_left - WH_A;
         nxt_col_base = col_base + rows_q;
         nxt_row_addr = col_base + rows_q;
      end
   end

   tile_extent #(.addr_width(addr_width), .width_height(width_height)) u_row_ext (
      .remaining (nxt_row_left),
      .extent    (ext_row)
   );

   tile_extent #(.addr_width(addr_width), .width_height(width_height)) u_col_ext (
      .remaining (nxt_col_left),
      .extent    (ext_col)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         mc_active    <= 1'b0;
         mc_base_addr <= '0;
         mc_num_row   <= '0;
         mc_num_col   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rows_q       <= '0;
         row_left     <= '0;
         col_left     <= '0;
         row_addr     <= '0;
         col_base     <= '0;
         abort_q      <= 1'b0;
      end else begin
         mc_active <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  rows_q  <= mat_rows;
                  abort_q <= 1'b0;
                  if (mat_rows == '0 || mat_cols == '0) begin
                     state <= S_FINISH;
                  end else begin
                     state        <= S_ISSUE;
                     mc_active    <= 1'b1;
                     row_left     <= nxt_row_left;
                     col_left     <= nxt_col_left;
                     row_addr     <= nxt_row_addr;
                     col_base     <= nxt_col_base;
                     mc_base_addr <= nxt_row_addr;
                     mc_num_row   <= ext_row;
                     mc_num_col   <= ext_col;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
               if (abort_hit) abort_q <= 1'b1;
            end
            S_WAIT: begin
               if (abort_hit) abort_q <= 1'b1;
               if (mc_done) begin
                  if (!(more_rows || more_cols) || abort_q || abort_hit) begin
                     state <= S_FINISH;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state        <= S_ISSUE;
                     mc_active    <= 1'b1;
                     row_left     <= nxt_row_left;
                     col_left     <= nxt_col_left;
                     row_addr     <= nxt_row_addr;
                     col_base     <= nxt_col_base;
                     mc_base_addr <= nxt_row_addr;
                     mc_num_row   <= ext_row;
                     mc_num_col   <= ext_col;
                  end
               end
            end
            S_FINISH: begin
               // An empty pass arrives here with done still low and spends one busy cycle first.
               if (done) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_master_tile_sequencer.sv
// Bench for master_tile_sequencer: hand tables, corner sequences and random passes vs a tile-list model.
module tb_master_tile_sequencer;
   localparam int AW = 8;
   localparam int WH = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          mc_done = 1'b0;
   logic [AW-1:0] mat_base_addr = '0;
   logic [AW-1:0] mat_rows = '0;
   logic [AW-1:0] mat_cols = '0;
   logic          mc_active, busy, done;
   logic [AW-1:0] mc_base_addr;
   logic [CW-1:0] mc_num_row, mc_num_col;
`ifdef MASTER_TILE_SEQ_ABORT_EN
   logic          abort = 1'b0;
`endif

   always #5 clk = ~clk;

   master_tile_sequencer #(.addr_width(AW), .width_height(WH)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .mat_base_addr (mat_base_addr),
      .mat_rows      (mat_rows),
      .mat_cols      (mat_cols),
      .mc_active     (mc_active),
      .mc_base_addr  (mc_base_addr),
      .mc_num_row    (mc_num_row),
      .mc_num_col    (mc_num_col),
      .mc_done       (mc_done),
`ifdef MASTER_TILE_SEQ_ABORT_EN
      .abort         (abort),
`endif
      .busy          (busy),
      .done          (done)
   );

   typedef struct {int addr; int nr; int nc;} tile_t;
   typedef struct {int base; int rows; int cols; int dly; bit glitch;
                   int n_tiles; int l_addr; int l_nr; int l_nc;} vec_t;

   tile_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int act_cnt = 0;
   int obs_cnt, obs_addr, obs_nr, obs_nc;

   always @(negedge clk) if (mc_active === 1'b1) act_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_active(output bit ok);
      int n;
      n = 0;
      while (mc_active !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      ok = (mc_active === 1'b1);
   endtask

   // Tile list straight from the addressing rule: column tiles outer, row tiles inner.
   task automatic build_model(input int base, input int rows, input int cols);
      exp_q.delete();
      for (int c = 0; c * WH < cols; c++) begin
         for (int r = 0; r * WH < rows; r++) begin
            tile_t t;
            t.addr = (base + c * rows + r * WH) % 256;
            t.nr   = (((rows - r * WH) < WH) ? (rows - r * WH) : WH) - 1;
            t.nc   = (((cols - c * WH) < WH) ? (cols - c * WH) : WH) - 1;
            exp_q.push_back(t);
         end
      end
   endtask

   task automatic run_pass(input int base, input int rows, input int cols, input int dly, input bit glitch);
      int t0;
      bit ok;
      build_model(base, rows, cols);
      t0 = act_cnt;
      obs_addr = -1; obs_nr = -1; obs_nc = -1;
      mat_base_addr = AW'(base);
      mat_rows = AW'(rows);
      mat_cols = AW'(cols);
      start = 1'b1;
      step();
      start = 1'b0;
      mat_base_addr = AW'($urandom);
      mat_rows = AW'($urandom);
      mat_cols = AW'($urandom);
      if (exp_q.size() == 0) begin
         check("zero_busy", 32'(busy), 1);
         check("zero_no_active", 32'(mc_active), 0);
         check("zero_done_early", 32'(done), 0);
         step();
         check("zero_done", 32'(done), 1);
         check("zero_busy_off", 32'(busy), 0);
         step();
         check("zero_done_clear", 32'(done), 0);
      end else begin
         foreach (exp_q[i]) begin
            check($sformatf("tile%0d_launch", i), 32'(mc_active), 1);
            if (mc_active !== 1'b1) begin
               wait_active(ok);
               check($sformatf("tile%0d_timeout", i), 32'(ok), 1);
            end
            check($sformatf("tile%0d_addr", i), 32'(mc_base_addr), exp_q[i].addr);
            check($sformatf("tile%0d_nr", i), 32'(mc_num_row), exp_q[i].nr);
            check($sformatf("tile%0d_nc", i), 32'(mc_num_col), exp_q[i].nc);
            check($sformatf("tile%0d_busy", i), 32'(busy), 1);
            obs_addr = int'(mc_base_addr);
            obs_nr = int'(mc_num_row);
            obs_nc = int'(mc_num_col);
            if (glitch && i == 0) mc_done = 1'b1;
            step();
            mc_done = 1'b0;
            check($sformatf("tile%0d_pulse", i), 32'(mc_active), 0);
            for (int d = 0; d < dly; d++) begin
               if (glitch && d == 0) begin
                  start = 1'b1;
                  mat_rows = 8'd1;
                  mat_cols = 8'd1;
               end
               step();
               start = 1'b0;
            end
            mc_done = 1'b1;
            step();
            mc_done = 1'b0;
         end
         check("done_pulse", 32'(done), 1);
         check("busy_at_done", 32'(busy), 0);
         check("no_extra_active", 32'(mc_active), 0);
         step();
         check("done_clear", 32'(done), 0);
         check("busy_idle", 32'(busy), 0);
      end
      obs_cnt = act_cnt - t0;
      check("tile_count_model", obs_cnt, exp_q.size());
   endtask

   initial begin
      vec_t vecs[7];
      bit ok;
      int t0;
      vecs[0] = '{'h10, 40, 20, 3, 1'b0, 6, 'h58, 7, 3};
      vecs[1] = '{'hF8, 16, 32, 1, 1'b0, 2, 'h08, 15, 15};
      vecs[2] = '{'h00, 1, 1, 0, 1'b0, 1, 'h00, 0, 0};
      vecs[3] = '{'h05, 17, 17, 2, 1'b1, 4, 'h26, 0, 0};
      vecs[4] = '{'h80, 255, 3, 0, 1'b0, 16, 'h70, 14, 2};
      vecs[5] = '{'h00, 0, 5, 0, 1'b0, 0, 0, 0, 0};
      vecs[6] = '{'h33, 7, 0, 0, 1'b0, 0, 0, 0, 0};

      #2;
      check("reset_outputs", 32'({mc_active, busy, done, mc_base_addr, mc_num_row, mc_num_col}), 0);
      step();
      step();
      reset = 1'b1;
      step();

      foreach (vecs[i]) begin
         run_pass(vecs[i].base, vecs[i].rows, vecs[i].cols, vecs[i].dly, vecs[i].glitch);
         check($sformatf("vec%0d_count", i), obs_cnt, vecs[i].n_tiles);
         if (vecs[i].n_tiles > 0) begin
            check($sformatf("vec%0d_last_addr", i), obs_addr, vecs[i].l_addr);
            check($sformatf("vec%0d_last_nr", i), obs_nr, vecs[i].l_nr);
            check($sformatf("vec%0d_last_nc", i), obs_nc, vecs[i].l_nc);
         end
      end

      // Reset in the middle of the second tile's WAIT.
      mat_base_addr = 8'h10;
      mat_rows = 8'd40;
      mat_cols = 8'd20;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_active(ok);
      check("rst_tile0_seen", 32'(ok), 1);
      step();
      mc_done = 1'b1;
      step();
      mc_done = 1'b0;
      wait_active(ok);
      check("rst_tile1_seen", 32'(ok), 1);
      step();
      #2;
      reset = 1'b0;
      #1;
      check("rst_async_clear", 32'({mc_active, busy, done, mc_base_addr, mc_num_row, mc_num_col}), 0);
      step();
      step();
      check("rst_no_done", 32'(done), 0);
      reset = 1'b1;
      step();
      step();
      check("rst_idle", 32'({busy, done, mc_active}), 0);
      run_pass('h44, 16, 16, 2, 1'b0);
      check("rst_fresh_count", obs_cnt, 1);
      check("rst_fresh_addr", obs_addr, 'h44);
      check("rst_fresh_nr", obs_nr, 15);
      check("rst_fresh_nc", obs_nc, 15);

`ifdef MASTER_TILE_SEQ_ABORT_EN
      t0 = act_cnt;
      mat_base_addr = 8'h10;
      mat_rows = 8'd40;
      mat_cols = 8'd20;
      start = 1'b1;
      step();
      start = 1'b0;
      check("abort_first_launch", 32'(mc_active), 1);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      mc_done = 1'b1;
      step();
      mc_done = 1'b0;
      check("abort_done", 32'(done), 1);
      check("abort_busy", 32'(busy), 0);
      for (int k = 0; k < 6; k++) step();
      check("abort_tile_count", act_cnt - t0, 1);
      check("abort_idle", 32'({busy, done}), 0);
`else
      t0 = act_cnt;
`endif

      for (int k = 0; k < 25; k++) begin
         run_pass(int'($urandom_range(0, 255)), int'($urandom_range(0, 60)),
                  int'($urandom_range(0, 60)), int'($urandom_range(0, 3)), 1'b0);
      end
      check("idle_after_random", 32'({busy, done, mc_active}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
